// File: rtl/bp_mem_dram_responder_pkg.sv
// Shared types for the DRAM responder: wormhole header layout, message and FSM
// encodings, and the size-to-beat-count helper.
package bp_me_dram_pkg;

    localparam int unsigned PaddrWidth = 40;
    localparam int unsigned CordWidth  = 7;
    localparam int unsigned LenWidth   = 4;
    localparam int unsigned BeatWidth  = LenWidth + 1;

    typedef enum logic [1:0] {
        e_dram_rd = 2'd0,
        e_dram_wr = 2'd1
    } bp_dram_msg_e;

    typedef enum logic [2:0] {
        e_ready,
        e_wr_data,
        e_rd_req,
        e_resp_hdr,
        e_rd_data
    } bp_dram_state_e;

    // Declared MSB first so that len lands in the flit LSBs.
    typedef struct packed {
        logic [PaddrWidth-1:0] addr;
        logic [2:0]            size;
        logic [1:0]            msg_type;
        logic [CordWidth-1:0]  src_cord;
        logic [CordWidth-1:0]  dst_cord;
        logic [LenWidth-1:0]   len;
    } bp_dram_hdr_s;

    function automatic logic [BeatWidth-1:0] size_to_beats(input logic [2:0] size);
        return (size <= 3'd3) ? BeatWidth'(1) : (BeatWidth'(1) << (size - 3'd3));
    endfunction

endpackage

// File: rtl/bp_mem_dram_responder_if.sv
// Ready/valid link bundle {v, data, ready_and_rev}. The master drives every field,
// the slave observes every field.
interface bp_mem_dram_responder_if #(
    parameter int unsigned flit_width_p = 64
);
    logic                    v;
    logic [flit_width_p-1:0] data;
    logic                    ready_and_rev;

    modport master (output v, data, ready_and_rev);
    modport slave  (input v, data, ready_and_rev);
endinterface

// File: rtl/bp_mem_dram_beat_gen.sv
// Maps (addr, size, beat) to a RAM word index and byte mask. Multi-word accesses
// wrap inside their size-aligned block, starting at the critical word.
module bp_mem_dram_beat_gen
    import bp_me_dram_pkg::*;
#(
    parameter int unsigned IdxW = 10
) (
    input  logic [IdxW-1:0]      base_i,
    input  logic [2:0]           offset_i,
    input  logic [2:0]           size_i,
    input  logic [BeatWidth-1:0] beat_i,
    output logic [IdxW-1:0]      addr_o,
    output logic [7:0]           mask_o
);

    logic [IdxW-1:0] blk;

    always_comb begin
        blk    = IdxW'(size_to_beats(size_i) - BeatWidth'(1));
        addr_o = (base_i & ~blk) | ((base_i + IdxW'(beat_i)) & blk);
        case (size_i)
            3'd0:    mask_o = 8'h01 << offset_i;
            3'd1:    mask_o = 8'h03 << offset_i;
            3'd2:    mask_o = 8'h0f << offset_i;
            default: mask_o = 8'hff;
        endcase
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables; the read data register
// holds its value until the next read. Contents are never reset.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int unsigned  els_p        = 1024,
    parameter int unsigned  data_width_p = 64,
    localparam int unsigned AddrW        = $clog2(els_p),
    localparam int unsigned MaskW        = data_width_p / 8
) (
    input  logic                    clk_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [AddrW-1:0]        addr_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic [MaskW-1:0]        write_mask_i,
    output logic [data_width_p-1:0] data_o
);

    logic [data_width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int b = 0; b < int'(MaskW); b++) begin
                if (write_mask_i[b]) mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
            end
        end
        if (v_i && !w_i) data_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/bp_mem_dram_responder.sv
// DRAM stand-in at the bottom of the mem complex: consumes one wormhole command
// packet at a time and answers it from a synchronous byte-masked RAM.
module bp_mem_dram_responder
    import bp_me_dram_pkg::*;
#(
    parameter int unsigned flit_width_p  = 64,
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned cord_width_p  = 7,
    parameter int unsigned len_width_p   = 4,
    parameter int unsigned mem_els_p     = 1024
) (
    input logic                     clk_i,
    input logic                     reset_n_i,
    bp_mem_dram_responder_if.slave  cmd_link_i,
    bp_mem_dram_responder_if.master resp_link_o
);

    localparam int unsigned IdxW = $clog2(mem_els_p);
    localparam int unsigned HdrW = paddr_width_p + 5 + 2 * cord_width_p + len_width_p;

    bp_dram_state_e          state_q, state_d;
    bp_dram_hdr_s            hdr_q, hdr_d, cmd_hdr, resp_hdr;
    logic [BeatWidth-1:0]    beat_q, beat_d, ram_beat, rd_beats;
    logic                    cmd_ready, cmd_fire, ram_v, ram_w, resp_v;
    logic [IdxW-1:0]         ram_addr;
    logic [7:0]              ram_mask;
    logic [flit_width_p-1:0] ram_rdata, resp_data;

    assign cmd_hdr   = cmd_link_i.data[HdrW-1:0];
    // Gated by reset so that ready is low while reset is held, not just after it.
    assign cmd_ready = reset_n_i && (state_q == e_ready || state_q == e_wr_data);
    assign cmd_fire  = cmd_ready && cmd_link_i.v;
    assign rd_beats  = size_to_beats(hdr_q.size);

    always_comb begin
        resp_hdr          = hdr_q;
        resp_hdr.dst_cord = hdr_q.src_cord;
        resp_hdr.src_cord = hdr_q.dst_cord;
        resp_hdr.len      = (hdr_q.msg_type == e_dram_rd) ? rd_beats[LenWidth-1:0] : '0;
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        beat_d    = beat_q;
        ram_v     = 1'b0;
        ram_w     = 1'b0;
        ram_beat  = beat_q;
        resp_v    = 1'b0;
        resp_data = '0;
        unique case (state_q)
            e_ready: begin
                if (cmd_fire) begin
                    hdr_d  = cmd_hdr;
                    beat_d = '0;
                    if (cmd_hdr.msg_type == e_dram_rd) state_d = e_rd_req;
                    else if (cmd_hdr.len != '0)        state_d = e_wr_data;
                    else                               state_d = e_resp_hdr;
                end
            end
            e_wr_data: begin
                if (cmd_fire) begin
                    // Reserved types drain their data flits without touching the RAM.
                    ram_v = (hdr_q.msg_type == e_dram_wr);
                    ram_w = 1'b1;
                    if (beat_q + BeatWidth'(1) == BeatWidth'(hdr_q.len)) begin
                        beat_d  = '0;
                        state_d = e_resp_hdr;
                    end else begin
                        beat_d = beat_q + BeatWidth'(1);
                    end
                end
            end
            e_rd_req: begin
                ram_v    = 1'b1;
                ram_beat = '0;
                state_d  = e_resp_hdr;
            end
            e_resp_hdr: begin
                resp_v    = 1'b1;
                resp_data = flit_width_p'(resp_hdr);
                if (cmd_link_i.ready_and_rev) begin
                    state_d = (hdr_q.msg_type == e_dram_rd) ? e_rd_data : e_ready;
                end
            end
            e_rd_data: begin
                resp_v    = 1'b1;
                resp_data = ram_rdata;
                if (cmd_link_i.ready_and_rev) begin
                    if (beat_q + BeatWidth'(1) == rd_beats) begin
                        beat_d  = '0;
                        state_d = e_ready;
                    end else begin
                        // Prefetch the next beat so data flits go out back to back.
                        beat_d   = beat_q + BeatWidth'(1);
                        ram_v    = 1'b1;
                        ram_beat = beat_q + BeatWidth'(1);
                    end
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            hdr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            beat_q  <= beat_d;
        end
    end

    bp_mem_dram_beat_gen #(
        .IdxW (IdxW)
    ) u_beat_gen (
        .base_i   (hdr_q.addr[3 +: IdxW]),
        .offset_i (hdr_q.addr[2:0]),
        .size_i   (hdr_q.size),
        .beat_i   (ram_beat),
        .addr_o   (ram_addr),
        .mask_o   (ram_mask)
    );

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (flit_width_p)
    ) u_ram (
        .clk_i        (clk_i),
        .v_i          (ram_v),
        .w_i          (ram_w),
        .addr_i       (ram_addr),
        .data_i       (cmd_link_i.data),
        .write_mask_i (ram_mask),
        .data_o       (ram_rdata)
    );

    assign resp_link_o.v             = resp_v;
    assign resp_link_o.data          = resp_data;
    assign resp_link_o.ready_and_rev = cmd_ready;

    wr_len_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_q == e_ready && cmd_fire && cmd_hdr.msg_type == e_dram_wr)
            |-> (BeatWidth'(cmd_hdr.len) == size_to_beats(cmd_hdr.size)));

endmodule
